vec_mul_feeder: RTL and testbench
=================================

Name: vec_mul_feeder

Overview:
- Initiator/controller for the vec_mul dot-product pipeline.
- Accepts operand vector pairs on a valid/ready stream and issues them to vec_mul.
- Tracks in-flight products and captures each returning result into a credit-protected result FIFO, so downstream backpressure never drops a product.
- Sits between the vector register file / load unit and the processing element.

Parameters:
C, 4, vector lanes per operand
W_X, 8, signed activation width
W_K, 8, signed weight width
W_Y, W_X+W_K+$clog2(C), signed result width
LATENCY, $clog2(C)+1, vec_mul enable-to-valid latency in cycles
FIFO_DEPTH, 4, result FIFO entries; must be >= LATENCY+1

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
s_valid  in  1  operand pair valid
s_ready  out  1  feeder can accept pair
s_x  in  C*W_X  packed signed activations, lane c at [c*W_X +: W_X]
s_k  in  C*W_K  packed signed weights, same packing
flush  in  1  stop accepting, drain everything, return to IDLE
mul_enable  out  1  issue strobe to vec_mul
mul_x  out  C*W_X  registered activations to vec_mul
mul_k  out  C*W_K  registered weights to vec_mul
mul_y  in  W_Y  vec_mul result
mul_valid  in  1  vec_mul result valid
m_valid  out  1  result available
m_ready  in  1  downstream accepts result
m_data  out  W_Y  signed dot product, FIFO head
busy  out  1  state != IDLE
done  out  1  one-cycle pulse on DRAIN->IDLE
err  out  1  sticky protocol error (see Optional Feature)

Behaviour:
- Reset values:
  - All outputs 0; mul_x, mul_k and m_data are 0.
  - FIFO empty; in-flight counter 0; state IDLE.
- State machine:
  - IDLE -> RUN on the first s_valid (same cycle: s_ready=1 in IDLE if credit is available).
  - RUN -> DRAIN on flush.
  - DRAIN -> IDLE when in_flight==0 and FIFO empty.
  - flush in IDLE is ignored.
- Credit:
  - credit_ok = in_flight + fifo_count < FIFO_DEPTH.
  - s_ready = credit_ok && state != DRAIN && !flush.
- Issue:
  - On s_valid && s_ready, next cycle: mul_x<=s_x, mul_k<=s_k, mul_enable=1 for exactly one cycle per accepted pair.
  - Back-to-back issue permitted every cycle.
- in_flight:
  - +1 on issue; −1 on mul_valid; both in the same cycle leaves it unchanged.
  - Width $clog2(FIFO_DEPTH+1).
- Capture:
  - mul_valid pushes mul_y into the FIFO.
  - Push is unconditional; credit guarantees the FIFO is never full when mul_valid arrives.
- Output:
  - m_valid = FIFO not empty; m_data = head; pop on m_valid && m_ready.
  - Push and pop in the same cycle leave the count unchanged.
  - Push on empty makes m_valid high the next cycle (no fall-through).
- Latency:
  - Accepted pair at cycle t: mul_enable at t+1.
  - mul_valid at t+1+LATENCY.
  - m_valid at t+2+LATENCY with m_ready held high.
- Boundary conditions:
  - FIFO full or credit exhausted: s_ready=0, no issue.
  - FIFO pointers wrap modulo FIFO_DEPTH.
  - Results leave in issue order.
  - Arithmetic is performed entirely inside vec_mul; the feeder never alters data.
- Reset mid-operation: all in-flight results are discarded; outputs return to reset values immediately (asynchronous).

Optional Feature:
- Macro VEC_FEED_CHECK_EN.
- Defined:
  - A LATENCY+1-deep shift register of issue strobes predicts each mul_valid.
  - Any mismatch (unexpected mul_valid, missing mul_valid, or mul_valid with in_flight==0) sets err, which clears only on reset.
- Not defined: err tied 0 and the shift register is absent.

Decomposition:
- Package vec_pkg holds:
  - C, W_X, W_K, W_Y, LATENCY constants.
  - typedef feed_state_e {IDLE, RUN, DRAIN}.
  - Packed typedefs for x_vec_t, k_vec_t, y_t.
- One sub-module vec_res_fifo: synchronous FIFO, parameters WIDTH and DEPTH; push, pop, data, full, empty, count; same clk/rstn.

Test Plan:
- Single pair x=32'h03020108, k=32'h01030309, m_ready=1: mul_enable 1 cycle after accept; m_data=84 at accept+2+LATENCY (accept+5 for C=4); m_valid low again the following cycle.
- Signed: every x lane 8'hFF, every k lane 8'h02: m_data=−8 (18'h3FFF8).
- Backpressure with m_ready=0:
  - Issue 6 pairs back-to-back; s_ready drops after 4 accepts; FIFO holds 4 results, no loss.
  - Raise m_ready: results drain in order and 2 more accepts follow.
- Stream 10 pairs, k=32'h01010101, x lanes all = i: results 4*i in order; m_valid continuous once the pipeline fills.
- flush after 3 issues with m_ready=1: s_ready=0 immediately; busy stays 1 until all 3 results are popped; done pulses once; state IDLE.
- rstn low while 2 in flight:
  - Outputs 0 asynchronously; FIFO empty after release.
  - With VEC_FEED_CHECK_EN, inject a spurious mul_valid: err=1 and sticky until reset.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared configuration and types for the vec_mul feeder slice.
package vec_pkg;

    localparam int unsigned C          = 4;
    localparam int unsigned W_X        = 8;
    localparam int unsigned W_K        = 8;
    localparam int unsigned W_Y        = W_X + W_K + $clog2(C);
    localparam int unsigned LATENCY    = $clog2(C) + 1;
    // Must cover LATENCY+1 so a result always finds a free slot.
    localparam int unsigned FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } feed_state_e;

    typedef logic [C*W_X-1:0]       x_vec_t;
    typedef logic [C*W_K-1:0]       k_vec_t;
    typedef logic signed [W_Y-1:0]  y_t;

endpackage

// File: rtl/vec_res_fifo.sv
// Synchronous result FIFO with occupancy count; head reads 0 while empty.
module vec_res_fifo #(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign data    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/vec_mul_feeder.sv
// Operand issue / result capture controller for the vec_mul pipeline.
// Optional VEC_FEED_CHECK_EN adds a mul_valid latency checker driving err.
module vec_mul_feeder
    import vec_pkg::*;
(
    input  logic               clk,
    input  logic               rstn,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [C*W_X-1:0]   s_x,
    input  logic [C*W_K-1:0]   s_k,
    input  logic               flush,
    output logic               mul_enable,
    output logic [C*W_X-1:0]   mul_x,
    output logic [C*W_K-1:0]   mul_k,
    input  logic [W_Y-1:0]     mul_y,
    input  logic               mul_valid,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [W_Y-1:0]     m_data,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int unsigned IFW = $clog2(FIFO_DEPTH + 1);

    feed_state_e    state;
    feed_state_e    state_nxt;
    logic [IFW-1:0] in_flight;
    logic [IFW-1:0] fifo_count;
    logic [IFW:0]   occupancy;
    logic           fifo_full;
    logic           fifo_empty;
    logic           credit_ok;
    logic           accept;
    logic           pop;
    logic           drained;

    // Credit counts products still inside vec_mul, so a result never meets a full FIFO.
    assign occupancy = {1'b0, in_flight} + {1'b0, fifo_count};
    assign credit_ok = (occupancy < (IFW+1)'(FIFO_DEPTH)) && !fifo_full;
    assign s_ready   = credit_ok && (state != DRAIN) && !flush;
    assign accept    = s_valid && s_ready;
    assign m_valid   = !fifo_empty;
    assign pop       = m_valid && m_ready;
    assign busy      = (state != IDLE);
    assign drained   = (in_flight == '0) && fifo_empty;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)  state_nxt = RUN;
            RUN:     if (flush)   state_nxt = DRAIN;
            DRAIN:   if (drained) state_nxt = IDLE;
            default:              state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            done       <= 1'b0;
            mul_enable <= 1'b0;
            mul_x      <= '0;
            mul_k      <= '0;
            in_flight  <= '0;
        end else begin
            state      <= state_nxt;
            done       <= (state == DRAIN) && drained;
            mul_enable <= accept;
            if (accept) begin
                mul_x <= s_x;
                mul_k <= s_k;
            end
            if (accept && !mul_valid) begin
                in_flight <= in_flight + IFW'(1);
            end else if (!accept && mul_valid && in_flight != '0) begin
                in_flight <= in_flight - IFW'(1);
            end
        end
    end

    vec_res_fifo #(
        .WIDTH (W_Y),
        .DEPTH (FIFO_DEPTH)
    ) u_res_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (mul_valid),
        .push_data (mul_y),
        .pop       (pop),
        .data      (m_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

`ifdef VEC_FEED_CHECK_EN
    // Bit 0 lines up with mul_enable; bit LATENCY marks the cycle mul_valid is due.
    logic [LATENCY:0] issue_sr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            issue_sr <= '0;
            err      <= 1'b0;
        end else begin
            issue_sr <= {issue_sr[LATENCY-1:0], accept};
            if ((mul_valid != issue_sr[LATENCY]) || (mul_valid && in_flight == '0)) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_vec_mul_feeder.sv
// Scoreboard bench for vec_mul_feeder with a behavioural vec_mul model.
module tb_vec_mul_feeder;

    localparam int L  = 3;
    localparam int WY = 18;

    logic            clk = 1'b0;
    logic            rstn;
    logic            s_valid, s_ready, flush;
    logic [31:0]     s_x, s_k, mul_x, mul_k;
    logic            mul_enable, mul_valid, inject;
    logic [WY-1:0]   mul_y, m_data;
    logic            m_valid, m_ready, busy, done, err;

    int total = 0;
    int bad   = 0;
    logic signed [WY-1:0] exp_q[$];
    logic [31:0]          vx[$];
    logic [31:0]          vk[$];
    logic signed [WY-1:0] ve[$];
    int acc;

    always #5 clk = ~clk;

    vec_mul_feeder dut (
        .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready),
        .s_x(s_x), .s_k(s_k), .flush(flush), .mul_enable(mul_enable),
        .mul_x(mul_x), .mul_k(mul_k), .mul_y(mul_y), .mul_valid(mul_valid),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .busy(busy), .done(done), .err(err)
    );

    // vec_mul stand-in: fixed L-cycle latency, reset together with the feeder.
    function automatic logic [WY-1:0] dot(input logic [31:0] x, input logic [31:0] k);
        int s = 0;
        for (int c = 0; c < 4; c++) begin
            logic signed [7:0] a, b;
            a = x[c*8 +: 8];
            b = k[c*8 +: 8];
            s += int'(a) * int'(b);
        end
        return WY'(s);
    endfunction

    logic [L-1:0]         pv;
    logic [L-1:0][WY-1:0] py;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pv <= '0;
            py <= '0;
        end else begin
            pv <= {pv[L-2:0], mul_enable};
            py <= {py[L-2:0], dot(mul_x, mul_k)};
        end
    end
    assign mul_valid = pv[L-1] | inject;
    assign mul_y     = py[L-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever a result is handed downstream.
    initial begin
        logic signed [WY-1:0] e;
        forever begin
            @(negedge clk);
            if (rstn && m_valid && m_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_result: got %0d expected none", $signed(m_data));
                end else begin
                    e = exp_q.pop_front();
                    if (m_data !== e) begin
                        bad++;
                        $display("FAIL result_data: got %0d expected %0d", $signed(m_data), e);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] x, input logic [31:0] k, input logic signed [WY-1:0] e);
        int n = 0;
        s_valid = 1'b1; s_x = x; s_k = k;
        @(negedge clk);
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_accepted", 64'(s_ready), 64'd1);
        if (s_ready) exp_q.push_back(e);
        tick();
        s_valid = 1'b0;
    endtask

    task automatic stream_run(input int max_cycles);
        logic hs;
        for (int c = 0; c < max_cycles && acc < vx.size(); c++) begin
            s_valid = 1'b1; s_x = vx[acc]; s_k = vk[acc];
            @(negedge clk);
            hs = s_ready;
            if (hs) exp_q.push_back(ve[acc]);
            tick();
            if (hs) acc++;
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || m_valid) && n < 100) begin
            tick();
            n++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
        tick();
        tick();
    endtask

    task automatic load_clear();
        vx.delete(); vk.delete(); ve.delete(); acc = 0;
    endtask

    initial begin
        int dn;
        logic seen_idle;
        logic signed [WY-1:0] bp_exp [6] = '{-18'sd12, -18'sd24, -18'sd36, -18'sd48, -18'sd60, -18'sd72};
        rstn = 1'b1; s_valid = 0; flush = 0; m_ready = 1; inject = 0; s_x = '0; s_k = '0;
        #3 rstn = 1'b0;
        #1;
        chk("rst_mul_enable", 64'(mul_enable), 0);
        chk("rst_mul_x", 64'(mul_x), 0);
        chk("rst_mul_k", 64'(mul_k), 0);
        chk("rst_m_valid", 64'(m_valid), 0);
        chk("rst_m_data", 64'(m_data), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_err", 64'(err), 0);
        @(negedge clk); @(negedge clk);
        rstn = 1'b1;
        tick();

        // Single pair: 8*9 + 1*3 + 2*3 + 3*1 = 84, result 5 cycles after accept.
        send(32'h03020108, 32'h01030309, 18'sd84);
        chk("issue_enable", 64'(mul_enable), 1);
        chk("issue_x", 64'(mul_x), 64'h03020108);
        chk("issue_k", 64'(mul_k), 64'h01030309);
        chk("busy_run", 64'(busy), 1);
        for (int i = 2; i <= 6; i++) begin
            tick();
            if (i == 2) chk("enable_one_cycle", 64'(mul_enable), 0);
            chk($sformatf("m_valid_c%0d", i), 64'(m_valid), 64'(i == 5));
        end

        // Signed: 4 * (-1 * 2) = -8.
        send(32'hFFFFFFFF, 32'h02020202, -18'sd8);
        wait_empty("signed_drain");

        // Backpressure: lanes i times -3 -> -12*i.
        load_clear();
        for (int i = 1; i <= 6; i++) begin
            vx.push_back({4{8'(i)}});
            vk.push_back(32'hFDFDFDFD);
            ve.push_back(bp_exp[i-1]);
        end
        m_ready = 1'b0;
        stream_run(12);
        chk("bp_accepts", 64'(acc), 4);
        chk("bp_s_ready_low", 64'(s_ready), 0);
        chk("bp_m_valid", 64'(m_valid), 1);
        chk("bp_fifo_held", 64'(exp_q.size()), 4);
        m_ready = 1'b1;
        stream_run(40);
        chk("bp_all_accepted", 64'(acc), 6);
        wait_empty("bp_drain");

        // Stream: lanes i times 1 -> 4*i.
        load_clear();
        for (int i = 1; i <= 10; i++) begin
            vx.push_back({4{8'(i)}});
            vk.push_back(32'h01010101);
            ve.push_back(WY'(4 * i));
        end
        stream_run(80);
        chk("stream_accepts", 64'(acc), 10);
        wait_empty("stream_drain");

        // Flush after three issues: 10, 40, -512.
        load_clear();
        vx.push_back(32'h01020304); vk.push_back(32'h01010101); ve.push_back(18'sd10);
        vx.push_back(32'h05050505); vk.push_back(32'h02020202); ve.push_back(18'sd40);
        vx.push_back(32'h80808080); vk.push_back(32'h01010101); ve.push_back(-18'sd512);
        stream_run(10);
        flush = 1'b1; s_valid = 1'b1;
        #1;
        chk("flush_s_ready", 64'(s_ready), 0);
        tick();
        flush = 1'b0;
        chk("drain_s_ready", 64'(s_ready), 0);
        chk("drain_busy", 64'(busy), 1);
        s_valid = 1'b0;
        dn = 0; seen_idle = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (done) dn++;
            if (!busy && !seen_idle) begin
                seen_idle = 1'b1;
                chk("busy_until_popped", 64'(exp_q.size()), 0);
            end
        end
        chk("done_once", 64'(dn), 1);
        chk("flush_idle", 64'(busy), 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_idle_ignored", 64'(busy), 0);

        // Reset with two products in flight.
        load_clear();
        vx.push_back(32'h01010101); vk.push_back(32'h01010101); ve.push_back(18'sd4);
        vx.push_back(32'h02020202); vk.push_back(32'h01010101); ve.push_back(18'sd8);
        stream_run(10);
        #2 rstn = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_enable", 64'(mul_enable), 0);
        chk("mid_rst_mul_x", 64'(mul_x), 0);
        chk("mid_rst_busy", 64'(busy), 0);
        chk("mid_rst_m_valid", 64'(m_valid), 0);
        chk("mid_rst_m_data", 64'(m_data), 0);
        @(negedge clk); @(negedge clk);
        rstn = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("post_rst_empty", 64'(m_valid), 0);
        end

`ifdef VEC_FEED_CHECK_EN
        chk("err_clear", 64'(err), 0);
        m_ready = 1'b0;
        inject = 1'b1;
        tick();
        inject = 1'b0;
        chk("err_set", 64'(err), 1);
        tick(); tick(); tick();
        chk("err_sticky", 64'(err), 1);
        @(negedge clk) rstn = 1'b0;
        #1;
        chk("err_reset", 64'(err), 0);
        @(negedge clk) rstn = 1'b1;
        m_ready = 1'b1;
        tick();
`endif
        chk("err_final", 64'(err), 0);
        chk("scoreboard_empty", 64'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
